// File: rtl/spi_pkg.sv
// spi_pkg: shared op encodings, frame widths, FSM state type and frame builder for spi_master.
`default_nettype none

package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    RECV  = 3'd4,
    GAP   = 3'd5
  } state_t;

  // Read-data frames carry a zero payload; the op MSB is sent twice as a leading marker.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] op,
                                                     input logic [DATA_W-1:0] data);
    build_frame = {op[1], op, (op == CMD_RD_DATA) ? {DATA_W{1'b0}} : data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spim_shifter.sv
// spim_shifter: frame shift-out register, MISO shift-in register and per-state bit counter.
`default_nettype none

module spim_shifter
  import spi_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [FRAME_W-1:0]   frame,
  input  logic                 shift,
  input  logic                 sample,
  input  logic                 cnt_clr,
  input  logic                 miso,
  output logic                 tx_bit,
  output logic [DATA_W-1:0]    rx_next,
  output logic [CNT_W-1:0]     bit_cnt
);

  logic [FRAME_W-1:0] tx_sreg;
  logic [DATA_W-2:0]  rx_sreg;

  assign tx_bit  = tx_sreg[FRAME_W-1];
  // Byte as it stands once the current MISO bit is included.
  assign rx_next = {rx_sreg, miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sreg <= '0;
      rx_sreg <= '0;
      bit_cnt <= '0;
    end else begin
      if (load)
        tx_sreg <= frame;
      else if (shift)
        tx_sreg <= {tx_sreg[FRAME_W-2:0], 1'b0};

      if (sample)
        rx_sreg <= rx_next[DATA_W-2:0];

      if (cnt_clr)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// spi_master: command-driven SPI master producing 11-bit frames and collecting 8-bit read data.
// Optional macro SPIM_FRAME_CNT_EN adds the frame_cnt[15:0] completed-frame counter output.
`default_nettype none

module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
`ifdef SPIM_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int CNT_W = 8;

  state_t             state;
  logic [1:0]         op_q;
  logic               load;
  logic               shift;
  logic               sample;
  logic               step_done;
  logic               tx_bit;
  logic [DATA_W-1:0]  rx_next;
  logic [CNT_W-1:0]   bit_cnt;

  // step_done marks the last cycle of the current state; the bit counter restarts there.
  always_comb begin
    step_done = 1'b0;
    case (state)
      IDLE:    step_done = 1'b1;
      START:   step_done = 1'b1;
      SHIFT:   step_done = (bit_cnt == CNT_W'(FRAME_W - 1));
      WAIT:    step_done = (bit_cnt == CNT_W'(RD_LATENCY - 1));
      RECV:    step_done = (bit_cnt == CNT_W'(DATA_W - 1));
      GAP:     step_done = (bit_cnt == CNT_W'(GAP_CYCLES - 1));
      default: step_done = 1'b1;
    endcase
  end

  assign load   = (state == IDLE) && cmd_valid;
  assign shift  = (state == START) || (state == SHIFT);
  assign sample = (state == RECV);

  spim_shifter #(
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .frame   (build_frame(cmd_op, cmd_data)),
    .shift   (shift),
    .sample  (sample),
    .cnt_clr (step_done),
    .miso    (MISO),
    .tx_bit  (tx_bit),
    .rx_next (rx_next),
    .bit_cnt (bit_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= CMD_WR_ADDR;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= START;
            op_q      <= cmd_op;
            SS_n      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          state <= SHIFT;
          MOSI  <= tx_bit;
        end
        SHIFT: begin
          if (step_done) begin
            MOSI <= 1'b0;
            if (op_q == CMD_RD_DATA) begin
              state <= WAIT;
            end else begin
              state <= GAP;
              SS_n  <= 1'b1;
            end
          end else begin
            MOSI <= tx_bit;
          end
        end
        WAIT: begin
          if (step_done)
            state <= RECV;
        end
        RECV: begin
          if (step_done) begin
            state     <= GAP;
            SS_n      <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_next;
          end
        end
        GAP: begin
          if (step_done) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPIM_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (((state == SHIFT) && step_done && (op_q != CMD_RD_DATA)) ||
             ((state == RECV) && step_done))
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with a behavioural SPI slave/RAM wrapper model.
`default_nettype none

module tb_spi_master;

  localparam int RDL = 2;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;
`ifdef SPIM_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  spi_master #(
    .RD_LATENCY (RDL),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
`ifdef SPIM_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  // Slave/RAM wrapper model: START cycle is index 0, MOSI bits are indices 1..11.
  logic [7:0]  mem [256];
  logic [7:0]  s_addr = 8'h00;
  logic [7:0]  s_rd = 8'h00;
  logic [10:0] s_sh = '0;
  int          s_cnt = 0;
  int          s_frames = 0;
  int          acc = 0;

  always @(posedge clk) begin
    if (SS_n) begin
      s_cnt = 0;
    end else begin
      if (s_cnt >= 1 && s_cnt <= 11)
        s_sh = {s_sh[9:0], MOSI};
      if (s_cnt == 11) begin
        s_frames++;
        case (s_sh[9:8])
          2'b00: s_addr = s_sh[7:0];
          2'b01: mem[s_addr] = s_sh[7:0];
          2'b10: s_addr = s_sh[7:0];
          default: s_rd = mem[s_addr];
        endcase
      end
      s_cnt++;
    end
    if (cmd_valid && cmd_ready)
      acc++;
  end

  always @(negedge clk) begin
    if (!SS_n && s_cnt >= 12 + RDL && s_cnt <= 19 + RDL)
      MISO = s_rd[19 + RDL - s_cnt];
    else
      MISO = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {15'd0, cmd_ready}, 16'd1);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    @(negedge clk);
    wait_ready("ready_before_send");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] exp);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {15'd0, rsp_valid}, 16'd1);
    chk(tag, {8'd0, rsp_data}, {8'd0, exp});
  endtask

  initial begin
    logic [10:0] exp_a5;
    int          frames_at;
    int          falls;
    int          hi_len;
    logic        prev_ss;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h3C] = 8'h96;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ss_n", {15'd0, SS_n}, 16'd1);
    chk("rst_mosi", {15'd0, MOSI}, 16'd0);
    chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    chk("rst_rsp_data", {8'd0, rsp_data}, 16'h0000);
    rst_n = 1'b1;

`ifdef SPIM_FRAME_CNT_EN
    chk("fc_reset", frame_cnt, 16'd0);
    send(2'b00, 8'h01);
    send(2'b00, 8'h02);
    send(2'b00, 8'h03);
    @(negedge clk);
    wait_ready("fc_ready3");
    chk("fc_three", frame_cnt, 16'd3);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("fc_preset", frame_cnt, 16'hFFFF);
    send(2'b00, 8'h04);
    @(negedge clk);
    wait_ready("fc_ready_wrap");
    chk("fc_wrap", frame_cnt, 16'd0);
`endif

    // Reset in the middle of a write-address frame
    send(2'b00, 8'h77);
    repeat (5) @(negedge clk);
    chk("mid_busy_before", {15'd0, busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ss_n_async", {15'd0, SS_n}, 16'd1);
    chk("mid_mosi", {15'd0, MOSI}, 16'd0);
    chk("mid_ready", {15'd0, cmd_ready}, 16'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", {15'd0, rsp_valid}, 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready_after", {15'd0, cmd_ready}, 16'd1);
    chk("mid_busy_after", {15'd0, busy}, 16'd0);

    // op 00, data A5: frame {0,00,A5}
    exp_a5 = 11'b000_1010_0101;
    send(2'b00, 8'hA5);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k <= 13) chk("a5_ss_n", {15'd0, SS_n}, {15'd0, (k > 12)});
      if (k >= 2 && k <= 12) chk("a5_mosi", {15'd0, MOSI}, {15'd0, exp_a5[12 - k]});
      else if (k <= 13) chk("a5_mosi_zero", {15'd0, MOSI}, 16'd0);
      if (k >= 13) chk("a5_ready", {15'd0, cmd_ready}, {15'd0, (k == 14)});
      chk("a5_no_rsp", {15'd0, rsp_valid}, 16'd0);
    end

    // Read RAM[3C] preloaded with 96
    send(2'b10, 8'h3C);
    send(2'b11, 8'hFF);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("rd_rsp_valid", {15'd0, rsp_valid}, {15'd0, (k == 23)});
      if (k == 22) chk("rd_ss_low", {15'd0, SS_n}, 16'd0);
      if (k == 23) begin
        chk("rd_ss_high", {15'd0, SS_n}, 16'd1);
        chk("rd_data", {8'd0, rsp_data}, 16'h0096);
        chk("rd_ready_gap", {15'd0, cmd_ready}, 16'd0);
      end
      if (k == 24) begin
        chk("rd_ready_idle", {15'd0, cmd_ready}, 16'd1);
        chk("rd_data_hold", {8'd0, rsp_data}, 16'h0096);
      end
    end

    // Write 5A to address 10, read back
    send(2'b00, 8'h10);
    send(2'b01, 8'h5A);
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    wait_rsp("rb_data", 8'h5A);

    // cmd_valid held high: three back-to-back write-address frames
    @(negedge clk);
    wait_ready("b2b_ready");
    frames_at = s_frames;
    acc       = 0;
    falls     = 0;
    hi_len    = 0;
    prev_ss   = SS_n;
    cmd_op    = 2'b00;
    cmd_data  = 8'h21;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 42) cmd_valid = 1'b0;
      if (prev_ss && !SS_n) begin
        if (falls > 0) chk("b2b_gap_len", 16'(hi_len), 16'(GAP + 1));
        falls++;
        hi_len = 0;
      end
      if (SS_n) hi_len++;
      prev_ss = SS_n;
    end
    chk("b2b_frames", 16'(falls), 16'd3);
    chk("b2b_accepts", 16'(acc), 16'd3);
    chk("b2b_slave_frames", 16'(s_frames - frames_at), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
